// File: rtl/systolic_tap_feeder.sv
// Sample window and tap sequencer feeding a sequential Booth multiplier.
// Optional build macro FEEDER_NEWEST_FIRST_EN walks the window newest-first instead of oldest-first.
module systolic_tap_feeder #(
  parameter int WORDLENGTH = 16,
  parameter int TAPS       = 8,
  parameter int ADDRBITS   = 3
) (
  input  logic                  wClk,
  input  logic                  reset,
  input  logic [WORDLENGTH-1:0] inputword,
  input  logic                  inclk,
  input  logic                  outclk,
  output logic [ADDRBITS-1:0]   coef_addr,
  input  logic [WORDLENGTH-1:0] coef_in,
  output logic [WORDLENGTH-1:0] mult_mpd,
  output logic [WORDLENGTH-1:0] mult_mpr,
  output logic                  mult_start,
  input  logic                  mult_busy,
  output logic                  tap_first,
  output logic                  tap_last,
  output logic                  frame_busy,
  output logic [ADDRBITS:0]     fill_count,
  output logic                  overrun
);

  localparam logic [ADDRBITS-1:0] LAST_TAP = ADDRBITS'(TAPS - 1);
  localparam logic [ADDRBITS:0]   FULL     = (ADDRBITS + 1)'(TAPS);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT_ACK, WAIT_DONE} state_t;
  state_t state;

  logic                  inclk_q, outclk_q;
  logic                  in_edge, out_edge;
  logic [WORDLENGTH-1:0] sample_buf [TAPS];
  logic [WORDLENGTH-1:0] pend_data;
  logic                  pend_valid;
  logic [ADDRBITS-1:0]   wr_ptr, wr_ptr_nxt, base, k, rd_idx;
  logic [ADDRBITS:0]     rd_sum;
  logic                  do_write;
  logic [WORDLENGTH-1:0] write_data;

  assign in_edge  = inclk & ~inclk_q;
  assign out_edge = outclk & ~outclk_q;

  // Writes land in the window only while IDLE; a waiting pending sample always goes first.
  always_comb begin
    do_write   = 1'b0;
    write_data = inputword;
    if (state == IDLE) begin
      if (pend_valid) begin
        do_write   = 1'b1;
        write_data = pend_data;
      end else if (in_edge) begin
        do_write = 1'b1;
      end
    end
    wr_ptr_nxt = wr_ptr;
    if (do_write) wr_ptr_nxt = (wr_ptr == LAST_TAP) ? '0 : wr_ptr + 1'b1;
`ifdef FEEDER_NEWEST_FIRST_EN
    rd_sum = {1'b0, base} + {1'b0, LAST_TAP - k};
`else
    rd_sum = {1'b0, base} + {1'b0, k};
`endif
    rd_idx = (rd_sum >= FULL) ? ADDRBITS'(rd_sum - FULL) : ADDRBITS'(rd_sum);
  end

  always_ff @(posedge wClk) begin
    if (reset) begin
      state      <= IDLE;
      inclk_q    <= 1'b0;
      outclk_q   <= 1'b0;
      pend_data  <= '0;
      pend_valid <= 1'b0;
      wr_ptr     <= '0;
      base       <= '0;
      k          <= '0;
      coef_addr  <= '0;
      mult_mpd   <= '0;
      mult_mpr   <= '0;
      mult_start <= 1'b0;
      tap_first  <= 1'b0;
      tap_last   <= 1'b0;
      frame_busy <= 1'b0;
      fill_count <= '0;
      overrun    <= 1'b0;
      for (int i = 0; i < TAPS; i++) sample_buf[i] <= '0;
    end else begin
      inclk_q    <= inclk;
      outclk_q   <= outclk;
      mult_start <= 1'b0;
      tap_first  <= 1'b0;
      tap_last   <= 1'b0;

      // An edge coinciding with a pending commit is parked and committed next cycle.
      if (state == IDLE) begin
        if (pend_valid) begin
          if (in_edge) pend_data <= inputword;
          else         pend_valid <= 1'b0;
        end
      end else if (in_edge) begin
        pend_data  <= inputword;
        pend_valid <= 1'b1;
        if (pend_valid) overrun <= 1'b1;
      end

      if (do_write) begin
        sample_buf[wr_ptr] <= write_data;
        wr_ptr             <= wr_ptr_nxt;
        if (fill_count != FULL) fill_count <= fill_count + 1'b1;
      end

      if (out_edge && state != IDLE) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (out_edge && fill_count == FULL) begin
            base       <= wr_ptr_nxt;
            k          <= '0;
            coef_addr  <= '0;
            frame_busy <= 1'b1;
            state      <= LOAD;
          end
        end
        LOAD: state <= ISSUE;
        ISSUE: begin
          mult_mpr   <= coef_in;
          mult_mpd   <= sample_buf[rd_idx];
          mult_start <= 1'b1;
          tap_first  <= (k == '0);
          tap_last   <= (k == LAST_TAP);
          state      <= WAIT_ACK;
        end
        WAIT_ACK: state <= WAIT_DONE;
        WAIT_DONE: begin
          if (!mult_busy) begin
            if (k == LAST_TAP) begin
              frame_busy <= 1'b0;
              state      <= IDLE;
            end else begin
              k         <= k + 1'b1;
              coef_addr <= k + 1'b1;
              state     <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
